// File: rtl/cmd_tag_engine.sv
// Tagged read-command issuer: streams num_lines commands at CMD_SIZE stride, tracks
// outstanding tags and credits, retires tags on responses. Optional macro: PARITY_CHECK_EN.
module cmd_tag_engine #(
  parameter int          NUM_TAGS = 4,
  parameter int          CMD_SIZE = 128,
  parameter logic [12:0] CMD_CODE = 13'h0A00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [0:63] base_ea,
  input  logic [0:15] num_lines,
  output logic        ah_cvalid,
  output logic [0:7]  ah_ctag,
  output logic        ah_ctagpar,
  output logic [0:12] ah_com,
  output logic        ah_compar,
  output logic [0:63] ah_cea,
  output logic        ah_ceapar,
  output logic [0:11] ah_csize,
  output logic [0:2]  ah_cabt,
  output logic [0:15] ah_cch,
  input  logic [0:7]  ha_croom,
  input  logic        ha_rvalid,
  input  logic [0:7]  ha_rtag,
  input  logic        ha_rtagpar,
  input  logic [0:7]  ha_response,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [0:1]  err_code
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FINISH, ERROR} state_t;

  state_t              r_state;
  logic [0:63]         r_ea;
  logic [15:0]         r_remaining;
  logic [7:0]          r_credits;
  logic [NUM_TAGS-1:0] r_outstanding;
  logic [1:0]          r_err_code;

  logic [7:0]          w_rtag;
  logic [15:0]         w_out16;
  logic                w_tag_known;
  logic                w_par_bad;
  logic                w_rsp;
  logic                w_rsp_err;
  logic                w_rsp_ok;
  logic [1:0]          w_err_code;
  logic                w_have_free;
  logic [3:0]          w_free_tag;
  logic                w_issue;
  logic [NUM_TAGS-1:0] w_free_mask;
  logic [NUM_TAGS-1:0] w_issue_mask;
  logic [NUM_TAGS-1:0] w_out_next;
  logic [7:0]          w_credits_next;

  assign w_rtag      = ha_rtag;
  assign w_out16     = 16'(r_outstanding);
  assign w_tag_known = (w_rtag < 8'(NUM_TAGS)) && w_out16[w_rtag[3:0]];

`ifdef PARITY_CHECK_EN
  assign w_par_bad = (ha_rtagpar != ^ha_rtag);
`else
  logic w_unused_rtagpar;
  assign w_unused_rtagpar = ha_rtagpar;
  assign w_par_bad        = 1'b0;
`endif

  // Responses are only meaningful while a job is active; IDLE drops them.
  assign w_rsp      = ha_rvalid && (r_state != IDLE);
  assign w_rsp_err  = w_rsp && (w_par_bad || !w_tag_known || (ha_response != 8'h00));
  assign w_rsp_ok   = w_rsp && !w_rsp_err;
  assign w_err_code = w_par_bad ? 2'b11 : (!w_tag_known ? 2'b10 : 2'b01);

  always_comb begin
    w_have_free = 1'b0;
    w_free_tag  = 4'd0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!r_outstanding[i]) begin
        w_have_free = 1'b1;
        w_free_tag  = 4'(i);
      end
    end
  end

  // A bad response in the same cycle blocks the issue decision so nothing leaves after the error.
  assign w_issue = (r_state == ISSUE) && enable && (r_credits != 8'd0) && w_have_free &&
                   (r_remaining != 16'd0) && !w_rsp_err;

  assign w_free_mask    = w_rsp_ok ? (NUM_TAGS'(1) << w_rtag[3:0]) : '0;
  assign w_issue_mask   = w_issue  ? (NUM_TAGS'(1) << w_free_tag)  : '0;
  assign w_out_next     = (r_outstanding & ~w_free_mask) | w_issue_mask;
  assign w_credits_next = r_credits - {7'd0, w_issue} + {7'd0, w_rsp_ok};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ea          <= '0;
      r_remaining   <= '0;
      r_credits     <= '0;
      r_outstanding <= '0;
      r_err_code    <= 2'b00;
      ah_cvalid     <= 1'b0;
      ah_ctag       <= '0;
      ah_com        <= '0;
      ah_cea        <= '0;
    end else begin
      ah_cvalid     <= w_issue;
      r_outstanding <= w_out_next;
      r_credits     <= w_credits_next;
      if (w_issue) begin
        ah_ctag     <= {4'b0000, w_free_tag};
        ah_com      <= CMD_CODE;
        ah_cea      <= r_ea;
        r_ea        <= r_ea + 64'(CMD_SIZE);
        r_remaining <= r_remaining - 16'd1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ea          <= base_ea;
            r_remaining   <= num_lines;
            r_credits     <= ha_croom;
            r_outstanding <= '0;
            r_state       <= (num_lines == 16'd0) ? FINISH : ISSUE;
          end
        end
        ISSUE:   if (r_remaining == 16'd0) r_state <= DRAIN;
        DRAIN:   if (w_out_next == '0) r_state <= FINISH;
        FINISH:  r_state <= IDLE;
        ERROR:   r_state <= ERROR;
        default: r_state <= IDLE;
      endcase
      // First error wins; later faults leave the recorded cause untouched.
      if (w_rsp_err && (r_state != ERROR)) begin
        r_state    <= ERROR;
        r_err_code <= w_err_code;
      end
    end
  end

  assign ah_ctagpar = ^ah_ctag;
  assign ah_compar  = ^ah_com;
  assign ah_ceapar  = ^ah_cea;
  assign ah_csize   = 12'(CMD_SIZE);
  assign ah_cabt    = 3'b000;
  assign ah_cch     = 16'h0000;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == FINISH);
  assign err        = (r_state == ERROR);
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_cmd_tag_engine.sv
// Bench for cmd_tag_engine: table of clean jobs plus hand sequences for stalls,
// credit limits, errors, mid-job reset and the PARITY_CHECK_EN option.
module tb_cmd_tag_engine;

  logic        clock = 1'b0;
  logic        reset, enable, start;
  logic [0:63] base_ea;
  logic [0:15] num_lines;
  logic        ah_cvalid, ah_ctagpar, ah_compar, ah_ceapar;
  logic [0:7]  ah_ctag;
  logic [0:12] ah_com;
  logic [0:63] ah_cea;
  logic [0:11] ah_csize;
  logic [0:2]  ah_cabt;
  logic [0:15] ah_cch;
  logic [0:7]  ha_croom, ha_rtag, ha_response;
  logic        ha_rvalid, ha_rtagpar;
  logic        busy, done, err;
  logic [0:1]  err_code;

  cmd_tag_engine dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .base_ea(base_ea), .num_lines(num_lines),
    .ah_cvalid(ah_cvalid), .ah_ctag(ah_ctag), .ah_ctagpar(ah_ctagpar),
    .ah_com(ah_com), .ah_compar(ah_compar), .ah_cea(ah_cea), .ah_ceapar(ah_ceapar),
    .ah_csize(ah_csize), .ah_cabt(ah_cabt), .ah_cch(ah_cch),
    .ha_croom(ha_croom), .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag),
    .ha_rtagpar(ha_rtagpar), .ha_response(ha_response),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  tag;
    logic [63:0] ea;
  } cmd_t;

  typedef struct {
    logic [63:0] base;
    logic [15:0] n;
    logic [7:0]  croom;
    logic [63:0] ea0, ea1, ea2, ea3;
  } job_t;

  cmd_t exp_q[$];
  cmd_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   n_cmds = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every issued command is popped against the expected queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (ah_cvalid) begin
        n_cmds++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd got tag=%0d ea=%h want=no command", ah_ctag, ah_cea);
        end else begin
          mon_e = exp_q.pop_front();
          check("cmd_tag", 64'(ah_ctag), 64'(mon_e.tag));
          check("cmd_ea", ah_cea, mon_e.ea);
          check("cmd_fields", 64'({ah_com, ah_csize, ah_cabt, ah_cch, ah_ctagpar, ah_compar, ah_ceapar}),
                64'({13'h0A00, 12'd128, 3'd0, 16'd0, ^mon_e.tag, 1'b0, ^mon_e.ea}));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    start = 1'b0;
    ha_rvalid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    exp_q.delete();
    n_cmds = 0;
    done_cnt = 0;
  endtask

  task automatic start_job(input logic [63:0] b, input logic [15:0] n, input logic [7:0] cr);
    base_ea = b;
    num_lines = n;
    ha_croom = cr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] tag, input logic [63:0] ea);
    cmd_t c;
    c.tag = tag;
    c.ea = ea;
    exp_q.push_back(c);
  endtask

  task automatic respond(input logic [7:0] tag, input logic [7:0] code, input logic par);
    ha_rvalid = 1'b1;
    ha_rtag = tag;
    ha_response = code;
    ha_rtagpar = par;
    tick();
    ha_rvalid = 1'b0;
  endtask

  task automatic respond_ok(input logic [7:0] tag);
    respond(tag, 8'h00, ^tag);
  endtask

  task automatic wait_cmds(input int n, input string name);
    int k = 0;
    while (n_cmds < n && k < 50) begin
      tick();
      k++;
    end
    check(name, 64'(n_cmds), 64'(n));
  endtask

  task automatic wait_done(input int d0, input string name);
    int k = 0;
    while (done_cnt == d0 && k < 50) begin
      tick();
      k++;
    end
    check(name, 64'(done_cnt - d0), 64'd1);
  endtask

  job_t        jobs[5];
  logic [63:0] eas[4];
  int          d0;

  initial begin
    jobs[0] = '{64'h1000, 16'd3, 8'd8, 64'h1000, 64'h1080, 64'h1100, 64'h0};
    jobs[1] = '{64'hFFFF_FFFF_FFFF_FFC0, 16'd2, 8'd4, 64'hFFFF_FFFF_FFFF_FFC0, 64'h40, 64'h0, 64'h0};
    jobs[2] = '{64'h0, 16'd0, 8'd4, 64'h0, 64'h0, 64'h0, 64'h0};
    jobs[3] = '{64'h12345, 16'd4, 8'd4, 64'h12345, 64'h123C5, 64'h12445, 64'h124C5};
    jobs[4] = '{64'h7F0, 16'd1, 8'd1, 64'h7F0, 64'h0, 64'h0, 64'h0};

    enable = 1'b1;
    base_ea = '0; num_lines = '0; ha_croom = '0;
    ha_rtag = '0; ha_response = '0; ha_rtagpar = 1'b0;
    do_reset();

    check("rst_cvalid", 64'(ah_cvalid), 64'd0);
    check("rst_tag", 64'(ah_ctag), 64'd0);
    check("rst_com", 64'(ah_com), 64'd0);
    check("rst_cea", ah_cea, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'({err, err_code}), 64'd0);

    // Clean jobs: all commands issued before any response, then retired in tag order.
    for (int i = 0; i < 5; i++) begin
      eas = '{jobs[i].ea0, jobs[i].ea1, jobs[i].ea2, jobs[i].ea3};
      n_cmds = 0;
      d0 = done_cnt;
      for (int k = 0; k < int'(jobs[i].n); k++) push(8'(k), eas[k]);
      start_job(jobs[i].base, jobs[i].n, jobs[i].croom);
      wait_cmds(int'(jobs[i].n), "job_cmds");
      if (jobs[i].n != 16'd0) begin
        repeat (3) tick();
        check("job_no_extra", 64'(n_cmds), 64'(jobs[i].n));
        check("job_busy", 64'(busy), 64'd1);
      end
      for (int k = 0; k < int'(jobs[i].n); k++) respond_ok(8'(k));
      wait_done(d0, "job_done");
      tick();
      check("job_done_pulse", 64'({busy, done}), 64'd0);
    end

    // Tag exhaustion stall, then a freed tag is reused lowest-first.
    n_cmds = 0;
    for (int k = 0; k < 4; k++) push(8'(k), 64'h4000 + 64'(k * 128));
    start_job(64'h4000, 16'd6, 8'd8);
    wait_cmds(4, "stall_first4");
    repeat (5) tick();
    check("stall_hold", 64'(n_cmds), 64'd4);
    push(8'd2, 64'h4200);
    respond_ok(8'd2);
    wait_cmds(5, "stall_reuse2");
    push(8'd0, 64'h4280);
    respond_ok(8'd0);
    wait_cmds(6, "stall_reuse0");
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) respond_ok(8'(k));
    wait_done(d0, "stall_done");

    // Single credit: second command waits for the first response.
    n_cmds = 0;
    push(8'd0, 64'h6000);
    start_job(64'h6000, 16'd2, 8'd1);
    wait_cmds(1, "credit1_first");
    repeat (4) tick();
    check("credit1_hold", 64'(n_cmds), 64'd1);
    push(8'd0, 64'h6080);
    respond_ok(8'd0);
    wait_cmds(2, "credit1_second");
    d0 = done_cnt;
    respond_ok(8'd0);
    wait_done(d0, "credit1_done");

    // Issue and response in the same cycle must not lose a credit.
    n_cmds = 0;
    push(8'd0, 64'h8000);
    push(8'd1, 64'h8080);
    start_job(64'h8000, 16'd4, 8'd2);
    wait_cmds(2, "credit2_first");
    repeat (3) tick();
    check("credit2_hold", 64'(n_cmds), 64'd2);
    push(8'd0, 64'h8100);
    push(8'd1, 64'h8180);
    respond_ok(8'd0);
    respond_ok(8'd1);
    wait_cmds(4, "credit2_simul");
    d0 = done_cnt;
    respond_ok(8'd0);
    respond_ok(8'd1);
    wait_done(d0, "credit2_done");

    // enable=0 suppresses issue only.
    n_cmds = 0;
    enable = 1'b0;
    push(8'd0, 64'hA000);
    d0 = done_cnt;
    start_job(64'hA000, 16'd1, 8'd4);
    repeat (4) tick();
    check("enable_gate", 64'(n_cmds), 64'd0);
    enable = 1'b1;
    wait_cmds(1, "enable_resume");
    respond_ok(8'd0);
    wait_done(d0, "enable_done");

    // Error response code stops issue and latches err.
    n_cmds = 0;
    push(8'd0, 64'hB000);
    push(8'd1, 64'hB080);
    start_job(64'hB000, 16'd6, 8'd2);
    wait_cmds(2, "errcode_cmds");
    respond(8'd0, 8'h01, 1'b0);
    check("errcode_flags", 64'({busy, err, err_code}), 64'b1101);
    repeat (5) tick();
    check("errcode_no_issue", 64'(n_cmds), 64'd2);
    check("errcode_sticky", 64'({busy, err, err_code}), 64'b1101);

    // Response to a tag that was never issued.
    do_reset();
    check("err_cleared", 64'({busy, err, err_code}), 64'd0);
    push(8'd0, 64'hC000);
    start_job(64'hC000, 16'd1, 8'd4);
    wait_cmds(1, "badtag5_cmds");
    respond_ok(8'd5);
    check("badtag5_flags", 64'({err, err_code}), 64'b110);

    do_reset();
    push(8'd0, 64'hC100);
    start_job(64'hC100, 16'd1, 8'd4);
    wait_cmds(1, "badtag3_cmds");
    respond_ok(8'd3);
    check("badtag3_flags", 64'({err, err_code}), 64'b110);

    // Reset mid-job abandons tags; responses in IDLE are dropped.
    do_reset();
    for (int k = 0; k < 3; k++) push(8'(k), 64'hD000 + 64'(k * 128));
    start_job(64'hD000, 16'd3, 8'd8);
    wait_cmds(3, "midrst_cmds");
    do_reset();
    respond_ok(8'd0);
    tick();
    check("midrst_ignored", 64'({busy, err, err_code}), 64'd0);
    push(8'd0, 64'hE000);
    d0 = done_cnt;
    start_job(64'hE000, 16'd1, 8'd4);
    wait_cmds(1, "midrst_fresh");
    respond_ok(8'd0);
    wait_done(d0, "midrst_done");

    // Response tag parity.
    n_cmds = 0;
    push(8'd0, 64'hF000);
    push(8'd1, 64'hF080);
    d0 = done_cnt;
    start_job(64'hF000, 16'd2, 8'd4);
    wait_cmds(2, "par_cmds");
    respond(8'd1, 8'h00, 1'b0);
`ifdef PARITY_CHECK_EN
    check("par_err", 64'({busy, err, err_code}), 64'b1111);
`else
    check("par_ignored", 64'({err, err_code}), 64'd0);
    respond_ok(8'd0);
    wait_done(d0, "par_done");
`endif
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_tag_engine.md
CMD_TAG_ENGINE -- requirements
Module: cmd_tag_engine

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 4, meaning maximum outstanding commands (1..16).
REQ-002 SHALL have parameter CMD_SIZE, default 128, meaning bytes per command; drives ah_csize and the address stride.
REQ-003 SHALL have parameter CMD_CODE, default 13'h0A00, meaning command code driven on ah_com (read_cl_na).
REQ-004 Ports, in order name / direction / width / meaning:
  clock in 1 clock; reset in 1 reset, synchronous, active-high;
  enable in 1 run gate; start in 1 one-cycle job start; base_ea in [0:63] first effective address; num_lines in [0:15] command count;
  ah_cvalid out 1 command valid; ah_ctag out [0:7] tag; ah_ctagpar out 1 tag parity; ah_com out [0:12] code; ah_compar out 1 code parity;
  ah_cea out [0:63] address; ah_ceapar out 1 address parity; ah_csize out [0:11] size; ah_cabt out [0:2] abort mode; ah_cch out [0:15] context;
  ha_croom in [0:7] command credits; ha_rvalid in 1 response valid; ha_rtag in [0:7] response tag; ha_rtagpar in 1 response tag parity; ha_response in [0:7] response code;
  busy out 1 job active; done out 1 one-cycle completion pulse; err out 1 sticky error; err_code out [0:1] error cause.

Function
REQ-005 SHALL use states IDLE, ISSUE, DRAIN, FINISH, ERROR.
REQ-006 IDLE: start=1 samples base_ea, num_lines, credits<=ha_croom; next state ISSUE, or FINISH when num_lines=0; start outside IDLE SHALL be ignored.
REQ-007 ISSUE: ah_cvalid=1 for exactly one cycle per command when enable=1, credits>0, a free tag exists and remaining>0; at most one command per cycle.
REQ-008 Command n (0-based) SHALL carry ah_cea=base_ea+n*CMD_SIZE (64-bit, wrap modulo 2^64), ah_com=CMD_CODE, ah_csize=CMD_SIZE, ah_cabt=0, ah_cch=0.
REQ-009 Tag SHALL be the lowest-numbered free tag in 0..NUM_TAGS-1, zero-extended to 8 bits; it is marked outstanding on issue.
REQ-010 Parity outputs SHALL be combinational XOR-reduction of ah_ctag, ah_com, ah_cea.
REQ-011 Credits SHALL decrement on each issue and increment on each accepted response; simultaneous issue and response leaves credits unchanged.
REQ-012 ha_rvalid with outstanding ha_rtag and ha_response=8'h00 SHALL free the tag; the tag is reusable the following cycle.
REQ-013 Response code nonzero -> ERROR, err_code=2'b01; tag not outstanding or ha_rtag>=NUM_TAGS -> ERROR, err_code=2'b10.
REQ-014 Responses SHALL be accepted in every state except IDLE, regardless of enable; enable=0 only suppresses new issue.
REQ-015 ISSUE -> DRAIN when remaining=0; DRAIN -> FINISH when no tag outstanding (same cycle as last response frees it).
REQ-016 FINISH: done=1 for one cycle, then IDLE.
REQ-017 ERROR: no further issue; err held 1 until reset; busy stays 1.
REQ-018 busy SHALL be 1 in ISSUE, DRAIN, FINISH, ERROR.

Reset
REQ-019 On reset: state IDLE, ah_cvalid=0, ah_ctag=0, ah_com=0, ah_cea=0, all tags free, credits=0, busy=0, done=0, err=0, err_code=0.
REQ-020 Reset mid-job SHALL abandon outstanding tags; later responses in IDLE SHALL be ignored.

Configuration
REQ-021 Macro PARITY_CHECK_EN: when defined, ha_rvalid with ha_rtagpar != XOR-reduction of ha_rtag SHALL enter ERROR with err_code=2'b11 and not free the tag; when undefined, ha_rtagpar SHALL be ignored.

Verification
REQ-022 start, base_ea=64'h1000, num_lines=3, croom=8, DONE responses -> tags 0,1,2 at 1000/1080/1100, done pulse after last response.
REQ-023 NUM_TAGS=4, num_lines=6, responses withheld -> exactly 4 commands issued, stalls; one response to tag 2 -> next command uses tag 2.
REQ-024 croom=1, num_lines=2 -> second command only after first response; issue and response same cycle keeps credits=1.
REQ-025 Response 8'h01 on tag 0 -> err=1, err_code=01, no further ah_cvalid; response to unissued tag 5 -> err_code=10.
REQ-026 PARITY_CHECK_EN defined, ha_rtag=8'h01 with ha_rtagpar=0 -> err_code=11; undefined -> tag freed, done.
